// File: rtl/al4s3b_wb_pkg.sv
// Shared types and default constants for the AL4S3B FPGA Wishbone interconnect.
package al4s3b_wb_pkg;

  localparam int unsigned WB_DATA_WIDTH = 32;

  localparam logic [WB_DATA_WIDTH-1:0] DEF_READ_VALUE = 32'hBAD_FAB_AC;

  localparam int unsigned DEF_APERWIDTH  = 17;
  localparam int unsigned DEF_APERSIZE   = 10;
  localparam int unsigned DEF_NUM_SLAVES = 4;

  localparam logic [DEF_NUM_SLAVES*DEF_APERWIDTH-1:0] DEF_BASE_ADDRESSES =
    {17'h07000, 17'h06000, 17'h05000, 17'h04000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    MISS = 2'd2,
    DONE = 2'd3
  } wb_state_t;

  // Width of a slave index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/al4s3b_wb_addr_decoder.sv
// Combinational priority decoder: matches the aperture tag against each slave
// base address; the lowest matching slot index wins.
module al4s3b_wb_addr_decoder
  import al4s3b_wb_pkg::*;
#(
  parameter int unsigned                        APERWIDTH      = DEF_APERWIDTH,
  parameter int unsigned                        APERSIZE       = DEF_APERSIZE,
  parameter int unsigned                        NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*APERWIDTH-1:0]    BASE_ADDRESSES = DEF_BASE_ADDRESSES,
  parameter int unsigned                        IDX_W          = idx_width(NUM_SLAVES)
) (
  input  logic [APERWIDTH-APERSIZE-1:0] tag,
  output logic                          hit,
  output logic [IDX_W-1:0]              idx
);

  localparam int unsigned TAG_W = APERWIDTH - APERSIZE;

  // Scan from the highest slot down so the lowest matching slot is the last writer.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = NUM_SLAVES; i > 0; i--) begin
      if (tag == BASE_ADDRESSES[(i-1)*APERWIDTH + APERSIZE +: TAG_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/al4s3b_fpga_wb_interconnect.sv
// Wishbone slave-side interconnect: address decode to per-slave CYC, ACK and
// read-data routing, plus a per-transfer watchdog that terminates unclaimed or
// unanswered accesses with a default value and logs them for firmware.
module al4s3b_fpga_wb_interconnect
  import al4s3b_wb_pkg::*;
#(
  parameter int unsigned                     APERWIDTH          = DEF_APERWIDTH,
  parameter int unsigned                     APERSIZE           = DEF_APERSIZE,
  parameter int unsigned                     NUM_SLAVES         = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*APERWIDTH-1:0] BASE_ADDRESSES     = DEF_BASE_ADDRESSES,
  parameter logic [31:0]                     DEFAULT_READ_VALUE = DEF_READ_VALUE,
  parameter int unsigned                     TIMEOUT_WIDTH      = 4,
  parameter int unsigned                     TIMEOUT_CYCLES     = 15,
  parameter int unsigned                     ERR_CNT_WIDTH      = 8
) (
  input  logic                       WBs_CLK_i,
  input  logic                       WBs_RST_n_i,
  input  logic [APERWIDTH-1:0]       WBs_ADR_i,
  input  logic                       WBs_CYC_i,
  input  logic                       WBs_STB_i,
  input  logic                       WBs_WE_i,
  output logic [31:0]                WBs_DAT_o,
  output logic                       WBs_ACK_o,
  output logic [NUM_SLAVES-1:0]      S_CYC_o,
  input  logic [NUM_SLAVES-1:0]      S_ACK_i,
  input  logic [NUM_SLAVES*32-1:0]   S_DAT_i,
  input  logic                       CLR_ERR_i,
  output logic [ERR_CNT_WIDTH-1:0]   ERR_CNT_o,
  output logic [APERWIDTH-1:0]       ERR_ADR_o,
  output logic                       ERR_FLAG_o
);

  localparam int unsigned IDX_W = idx_width(NUM_SLAVES);
  localparam int unsigned TAG_W = APERWIDTH - APERSIZE;

  wb_state_t              state;
  logic [IDX_W-1:0]       sel_q;
  logic [APERWIDTH-1:0]   adr_q;
  logic                   we_q;
  logic [TIMEOUT_WIDTH-1:0] wd;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic                   sel_ack;
  logic [31:0]            sel_dat;
  logic                   wd_expired;
  logic                   log_err;

  al4s3b_wb_addr_decoder #(
    .APERWIDTH      (APERWIDTH),
    .APERSIZE       (APERSIZE),
    .NUM_SLAVES     (NUM_SLAVES),
    .BASE_ADDRESSES (BASE_ADDRESSES),
    .IDX_W          (IDX_W)
  ) u_decoder (
    .tag (WBs_ADR_i[APERWIDTH-1:APERSIZE]),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  // Selected-slave routing, slave cycle select and error-event qualification.
  always_comb begin
    sel_ack    = S_ACK_i[sel_q];
    sel_dat    = S_DAT_i[{sel_q, 5'b0} +: 32];
    wd_expired = (wd == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    log_err    = WBs_CYC_i &&
                 ((state == MISS) || ((state == BUSY) && !sel_ack && wd_expired));
    S_CYC_o    = '0;
    if (state == BUSY) S_CYC_o[sel_q] = WBs_CYC_i;
  end

  // Transfer FSM with registered ACK and read data; DONE is a one-cycle bubble.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      state     <= IDLE;
      sel_q     <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      wd        <= '0;
      WBs_ACK_o <= 1'b0;
      WBs_DAT_o <= '0;
    end else begin
      WBs_ACK_o <= 1'b0;
      case (state)
        IDLE: begin
          if (WBs_CYC_i && WBs_STB_i) begin
            sel_q <= dec_idx;
            adr_q <= WBs_ADR_i;
            we_q  <= WBs_WE_i;
            wd    <= '0;
            state <= dec_hit ? BUSY : MISS;
          end
        end
        BUSY: begin
          if (!WBs_CYC_i) begin
            state <= IDLE;
          end else if (sel_ack) begin
            // Write data goes straight to the slave; the read mux is only loaded on reads.
            WBs_ACK_o <= 1'b1;
            if (!we_q) WBs_DAT_o <= sel_dat;
            state <= DONE;
          end else if (wd_expired) begin
            WBs_ACK_o <= 1'b1;
            WBs_DAT_o <= DEFAULT_READ_VALUE;
            state     <= DONE;
          end else begin
            wd <= wd + TIMEOUT_WIDTH'(1);
          end
        end
        MISS: begin
          if (!WBs_CYC_i) begin
            state <= IDLE;
          end else begin
            WBs_ACK_o <= 1'b1;
            WBs_DAT_o <= DEFAULT_READ_VALUE;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Error log; a new error takes precedence over a coincident clear.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      ERR_CNT_o  <= '0;
      ERR_ADR_o  <= '0;
      ERR_FLAG_o <= 1'b0;
    end else if (log_err) begin
      ERR_ADR_o  <= adr_q;
      ERR_FLAG_o <= 1'b1;
      if (CLR_ERR_i)            ERR_CNT_o <= ERR_CNT_WIDTH'(1);
      else if (ERR_CNT_o != '1) ERR_CNT_o <= ERR_CNT_o + ERR_CNT_WIDTH'(1);
    end else if (CLR_ERR_i) begin
      ERR_CNT_o  <= '0;
      ERR_ADR_o  <= '0;
      ERR_FLAG_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_al4s3b_fpga_wb_interconnect.sv
// Directed bench for the Wishbone interconnect: hit, miss, timeout, error log
// saturation/clear, abort, async reset and overlapping apertures.
module tb_al4s3b_fpga_wb_interconnect;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [16:0]  adr;
  logic         cyc, stb, we, clr;
  logic [31:0]  dat;
  logic         ack;
  logic [3:0]   s_cyc, s_ack;
  logic [127:0] s_dat;
  logic [7:0]   err_cnt;
  logic [16:0]  err_adr;
  logic         err_flag;

  logic [31:0]  ov_dat;
  logic         ov_ack;
  logic [3:0]   ov_s_cyc, ov_s_ack;
  logic [127:0] ov_s_dat;
  logic [7:0]   ov_err_cnt;
  logic [16:0]  ov_err_adr;
  logic         ov_err_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_at;

  always #5 clk = ~clk;

  al4s3b_fpga_wb_interconnect dut (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .WBs_ADR_i(adr), .WBs_CYC_i(cyc),
    .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_DAT_o(dat), .WBs_ACK_o(ack),
    .S_CYC_o(s_cyc), .S_ACK_i(s_ack), .S_DAT_i(s_dat), .CLR_ERR_i(clr),
    .ERR_CNT_o(err_cnt), .ERR_ADR_o(err_adr), .ERR_FLAG_o(err_flag)
  );

  al4s3b_fpga_wb_interconnect #(
    .BASE_ADDRESSES({17'h07000, 17'h04000, 17'h05000, 17'h04000})
  ) dut_ov (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .WBs_ADR_i(adr), .WBs_CYC_i(cyc),
    .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_DAT_o(ov_dat), .WBs_ACK_o(ov_ack),
    .S_CYC_o(ov_s_cyc), .S_ACK_i(ov_s_ack), .S_DAT_i(ov_s_dat), .CLR_ERR_i(clr),
    .ERR_CNT_o(ov_err_cnt), .ERR_ADR_o(ov_err_adr), .ERR_FLAG_o(ov_err_flag)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [16:0] a);
    adr = a; cyc = 1'b1; stb = 1'b1;
    tick();
  endtask

  task automatic end_xfer();
    cyc = 1'b0; stb = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; clr = 1'b0;
    s_ack = '0; s_dat = '0; ov_s_ack = '0; ov_s_dat = '0;
    #12;
    check_eq("rst_ack", ack, 0);
    check_eq("rst_dat", dat, 0);
    check_eq("rst_scyc", s_cyc, 0);
    check_eq("rst_cnt", err_cnt, 0);
    check_eq("rst_eadr", err_adr, 0);
    check_eq("rst_flag", err_flag, 0);
    rst_n = 1'b1;
    tick();

    // Hit on slave 1, slave acks two cycles after select.
    start(17'h05004);
    check_eq("hit_scyc", s_cyc, 4'b0010);
    check_eq("hit_ack_early0", ack, 0);
    tick();
    check_eq("hit_ack_early1", ack, 0);
    s_ack = 4'b0010; s_dat[63:32] = 32'hCAFE0001;
    tick();
    s_ack = '0;
    check_eq("hit_ack", ack, 1);
    check_eq("hit_dat", dat, 32'hCAFE0001);
    check_eq("hit_scyc_done", s_cyc, 0);
    check_eq("hit_cnt", err_cnt, 0);
    end_xfer();
    check_eq("hit_ack_one_cycle", ack, 0);
    check_eq("hit_dat_hold", dat, 32'hCAFE0001);

    // Miss: no aperture matches.
    start(17'h1F000);
    check_eq("miss_ack_early", ack, 0);
    check_eq("miss_scyc", s_cyc, 0);
    tick();
    check_eq("miss_ack", ack, 1);
    check_eq("miss_dat", dat, 32'hBADFABAC);
    check_eq("miss_cnt", err_cnt, 1);
    check_eq("miss_eadr", err_adr, 17'h1F000);
    check_eq("miss_flag", err_flag, 1);
    end_xfer();

    // Timeout on slave 0.
    start(17'h04010);
    check_eq("to_scyc", s_cyc, 4'b0001);
    ack_at = 0;
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      tick();
      if (ack === 1'b1) ack_at = k;
    end
    check_eq("to_latency", ack_at, 15);
    check_eq("to_dat", dat, 32'hBADFABAC);
    check_eq("to_flag", err_flag, 1);
    check_eq("to_cnt", err_cnt, 2);
    check_eq("to_eadr", err_adr, 17'h04010);
    end_xfer();

    // Clear, then ack lands on the last watchdog cycle: ack wins.
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("clr_cnt", err_cnt, 0);
    check_eq("clr_flag", err_flag, 0);
    check_eq("clr_eadr", err_adr, 0);
    start(17'h04020);
    repeat (14) tick();
    check_eq("edge_ack_early", ack, 0);
    s_ack = 4'b0001; s_dat[31:0] = 32'h12345678;
    tick();
    s_ack = '0;
    check_eq("edge_ack", ack, 1);
    check_eq("edge_dat", dat, 32'h12345678);
    check_eq("edge_flag", err_flag, 0);
    check_eq("edge_cnt", err_cnt, 0);
    end_xfer();

    // Counter saturation over 300 misses.
    for (int i = 0; i < 300; i++) begin
      adr = 17'h1F000; cyc = 1'b1; stb = 1'b1;
      tick(); tick();
      cyc = 1'b0; stb = 1'b0;
      tick();
    end
    check_eq("sat_cnt", err_cnt, 8'hFF);
    check_eq("sat_flag", err_flag, 1);

    // Clear coinciding with a new miss: the new error wins.
    start(17'h1E400);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clrhit_ack", ack, 1);
    check_eq("clrhit_cnt", err_cnt, 1);
    check_eq("clrhit_flag", err_flag, 1);
    check_eq("clrhit_eadr", err_adr, 17'h1E400);
    end_xfer();

    // Master abort mid-BUSY.
    start(17'h06000);
    check_eq("abort_scyc", s_cyc, 4'b0100);
    tick();
    cyc = 1'b0; stb = 1'b0;
    #1;
    check_eq("abort_scyc_drop", s_cyc, 0);
    tick();
    check_eq("abort_ack0", ack, 0);
    tick();
    check_eq("abort_ack1", ack, 0);
    check_eq("abort_cnt", err_cnt, 1);

    // Asynchronous reset mid-transfer.
    start(17'h07000);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ack", ack, 0);
    check_eq("arst_dat", dat, 0);
    check_eq("arst_scyc", s_cyc, 0);
    check_eq("arst_cnt", err_cnt, 0);
    check_eq("arst_eadr", err_adr, 0);
    check_eq("arst_flag", err_flag, 0);
    cyc = 1'b0; stb = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    start(17'h07008);
    check_eq("post_rst_scyc", s_cyc, 4'b1000);
    s_ack = 4'b1000; s_dat[127:96] = 32'h0A5A5A5A;
    tick();
    s_ack = '0;
    check_eq("post_rst_ack", ack, 1);
    check_eq("post_rst_dat", dat, 32'h0A5A5A5A);
    end_xfer();

    // Overlapping apertures: slot 0 wins, spurious ack on slot 2 ignored.
    start(17'h04000);
    check_eq("ov_scyc", ov_s_cyc, 4'b0001);
    ov_s_ack = 4'b0100; ov_s_dat[95:64] = 32'hDEADBEEF;
    tick();
    check_eq("ov_spurious_ack", ov_ack, 0);
    ov_s_ack = 4'b0001; ov_s_dat[31:0] = 32'h11112222;
    tick();
    ov_s_ack = '0;
    check_eq("ov_ack", ov_ack, 1);
    check_eq("ov_dat", ov_dat, 32'h11112222);
    end_xfer();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
